xilinx_sdp_fifo_ctrl: RTL and testbench

XILINX_SDP_FIFO_CTRL -- requirements
Module: xilinx_sdp_fifo_ctrl

---
 rtl/xilinx_sdp_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_xilinx_sdp_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xilinx_sdp_fifo_ctrl
// Description : Valid/ready FWFT FIFO controller driving a simple-dual-port
//               BRAM, with an (L+1)-entry output buffer for full throughput.
//               Optional write-stall counter: XILINX_SDP_FIFO_CTRL_STALL_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module xilinx_sdp_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DO_REG     = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  output logic [14:0]           BRAM_WRADDR,
  output logic [7:0]            BRAM_WE,
  output logic                  BRAM_WREN,
  output logic [14:0]           BRAM_RDADDR,
  output logic                  BRAM_RDEN,
  output logic                  BRAM_REGCE,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  output logic [ADDR_WIDTH+1:0] COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [15:0]           STALL_CNT
);

  localparam int c_LAT      = 1 + DO_REG;
  localparam int c_OB_DEPTH = c_LAT + 1;
  localparam int c_OB_PW    = (c_OB_DEPTH > 2) ? 2 : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_cnt;
  logic [c_LAT-1:0]      r_rd_vld;
  logic [1:0]            r_ob_cnt;
  logic [c_OB_PW-1:0]    r_ob_wptr;
  logic [c_OB_PW-1:0]    r_ob_rptr;
  logic [DATA_WIDTH-1:0] r_ob_mem [c_OB_DEPTH];

  logic       w_wr_acc;
  logic       w_rd_iss;
  logic       w_pop;
  logic       w_cap;
  logic [1:0] w_inflight;
  logic [2:0] w_commit;

  function automatic logic [c_OB_PW-1:0] ob_next(input logic [c_OB_PW-1:0] p);
    return (p == c_OB_PW'(c_OB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign WR_READY = (r_mem_cnt != c_DEPTH);
  assign w_wr_acc = WR_VALID && WR_READY;
  assign RD_VALID = (r_ob_cnt != 2'd0);
  assign w_pop    = RD_VALID && RD_READY;
  assign w_cap    = r_rd_vld[c_LAT-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_LAT; i++) begin
      w_inflight = w_inflight + {1'b0, r_rd_vld[i]};
    end
  end

  // The word popped this cycle frees its slot, so it is credited back before
  // deciding on a new read; this keeps one word per cycle in steady state.
  assign w_commit = {1'b0, r_ob_cnt} + {1'b0, w_inflight} - {2'b00, w_pop};
  assign w_rd_iss = (r_mem_cnt != '0) && (w_commit < 3'(c_OB_DEPTH));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_rd_vld  <= '0;
      r_ob_cnt  <= '0;
      r_ob_wptr <= '0;
      r_ob_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_iss) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_cnt <= r_mem_cnt + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_iss);
      r_rd_vld  <= (r_rd_vld << 1) | c_LAT'(w_rd_iss);
      r_ob_cnt  <= r_ob_cnt + {1'b0, w_cap} - {1'b0, w_pop};
      if (w_cap) r_ob_wptr <= ob_next(r_ob_wptr);
      if (w_pop) r_ob_rptr <= ob_next(r_ob_rptr);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_cap) r_ob_mem[r_ob_wptr] <= BRAM_DO;
  end

  assign BRAM_WREN   = w_wr_acc;
  assign BRAM_WE     = w_wr_acc ? 8'hFF : 8'h00;
  assign BRAM_DI     = WR_DATA;
  assign BRAM_WRADDR = 15'(r_wr_ptr);
  assign BRAM_RDEN   = w_rd_iss;
  assign BRAM_RDADDR = 15'(r_rd_ptr);
  assign BRAM_REGCE  = (DO_REG != 0);

  assign RD_DATA = r_ob_mem[r_ob_rptr];
  assign COUNT   = (ADDR_WIDTH+2)'(r_mem_cnt) + (ADDR_WIDTH+2)'(w_inflight)
                 + (ADDR_WIDTH+2)'(r_ob_cnt);
  assign FULL    = !WR_READY;
  assign EMPTY   = !RD_VALID;

`ifdef XILINX_SDP_FIFO_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (WR_VALID && !WR_READY && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`else
  assign STALL_CNT = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xilinx_sdp_fifo_ctrl.sv
`default_nettype none
// Testbench for xilinx_sdp_fifo_ctrl: DO_REG=0 and DO_REG=1 instances with
// behavioural BRAMs, directed stimulus and a queue-based read scoreboard.
module tb_xilinx_sdp_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- instance 0: DO_REG = 0 ----------------
  logic          wr_valid0, wr_ready0, rd_valid0, rd_ready0;
  logic [DW-1:0] wr_data0, rd_data0, bram_di0, bram_do0;
  logic [14:0]   bram_wraddr0, bram_rdaddr0;
  logic [7:0]    bram_we0;
  logic          bram_wren0, bram_rden0, bram_regce0, full0, empty0;
  logic [AW+1:0] count0;
  logic [15:0]   stall0;

  xilinx_sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DO_REG(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n),
    .WR_VALID(wr_valid0), .WR_READY(wr_ready0), .WR_DATA(wr_data0),
    .RD_VALID(rd_valid0), .RD_READY(rd_ready0), .RD_DATA(rd_data0),
    .BRAM_DI(bram_di0), .BRAM_WRADDR(bram_wraddr0), .BRAM_WE(bram_we0),
    .BRAM_WREN(bram_wren0), .BRAM_RDADDR(bram_rdaddr0), .BRAM_RDEN(bram_rden0),
    .BRAM_REGCE(bram_regce0), .BRAM_DO(bram_do0),
    .COUNT(count0), .FULL(full0), .EMPTY(empty0), .STALL_CNT(stall0)
  );

  logic [DW-1:0] mem0 [16];
  always @(posedge clk) begin
    if (bram_wren0) mem0[bram_wraddr0[3:0]] <= bram_di0;
    if (bram_rden0) bram_do0 <= mem0[bram_rdaddr0[3:0]];
  end

  // ---------------- instance 1: DO_REG = 1 ----------------
  logic          wr_valid1, wr_ready1, rd_valid1, rd_ready1;
  logic [DW-1:0] wr_data1, rd_data1, bram_di1, bram_do1, lat1;
  logic [14:0]   bram_wraddr1, bram_rdaddr1;
  logic [7:0]    bram_we1;
  logic          bram_wren1, bram_rden1, bram_regce1, full1, empty1;
  logic [AW+1:0] count1;
  logic [15:0]   stall1;

  xilinx_sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DO_REG(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n),
    .WR_VALID(wr_valid1), .WR_READY(wr_ready1), .WR_DATA(wr_data1),
    .RD_VALID(rd_valid1), .RD_READY(rd_ready1), .RD_DATA(rd_data1),
    .BRAM_DI(bram_di1), .BRAM_WRADDR(bram_wraddr1), .BRAM_WE(bram_we1),
    .BRAM_WREN(bram_wren1), .BRAM_RDADDR(bram_rdaddr1), .BRAM_RDEN(bram_rden1),
    .BRAM_REGCE(bram_regce1), .BRAM_DO(bram_do1),
    .COUNT(count1), .FULL(full1), .EMPTY(empty1), .STALL_CNT(stall1)
  );

  logic [DW-1:0] mem1 [16];
  always @(posedge clk) begin
    if (bram_wren1) mem1[bram_wraddr1[3:0]] <= bram_di1;
    if (bram_rden1) lat1 <= mem1[bram_rdaddr1[3:0]];
    if (bram_regce1) bram_do1 <= lat1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int n_pop1 = 0, first_pop1 = 0, last_pop1 = 0, first_wr1 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid0 && rd_ready0) begin
        if (exp_q0.size() == 0) chk("pop0_unexpected", 1, 0);
        else chk("rd_data0", rd_data0, exp_q0.pop_front());
      end
      if (bram_wren0) chk("bram_we0", bram_we0, 8'hFF);
      else            chk("bram_we0_idle", bram_we0, 8'h00);
      if (bram_wren0 && bram_rden0)
        chk("addr_collision0", (bram_wraddr0 == bram_rdaddr0), 0);
      if (rd_valid1 && rd_ready1) begin
        if (n_pop1 == 0) first_pop1 = cyc;
        last_pop1 = cyc;
        n_pop1++;
        if (exp_q1.size() == 0) chk("pop1_unexpected", 1, 0);
        else chk("rd_data1", rd_data1, exp_q1.pop_front());
      end
      if (bram_wren1 && bram_rden1)
        chk("addr_collision1", (bram_wraddr1 == bram_rdaddr1), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word0(input logic [DW-1:0] d, output bit acc);
    wr_valid0 = 1'b1;
    wr_data0  = d;
    acc       = wr_ready0;
    if (acc) exp_q0.push_back(d);
    tick();
    wr_valid0 = 1'b0;
  endtask

  task automatic wait_rv0(input int max);
    int k = 0;
    while (!rd_valid0 && k < max) begin
      tick();
      k++;
    end
    chk("rd_valid0_wait", rd_valid0, 1);
  endtask

  task automatic drain0(input int max);
    int k = 0;
    rd_ready0 = 1'b1;
    while (exp_q0.size() != 0 && k < max) begin
      tick();
      k++;
    end
    rd_ready0 = 1'b0;
    chk("drain0_left", exp_q0.size(), 0);
    chk("drain0_empty", empty0, 1);
    chk("drain0_count", count0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    bit acc;
    int acc_n;
    int k;
    logic [15:0] stall_exp_base;
    logic [15:0] stall_exp_delta;
    logic [15:0] stall_before;
`ifdef XILINX_SDP_FIFO_CTRL_STALL_CNT_EN
    stall_exp_base  = 16'd2;
    stall_exp_delta = 16'd5;
`else
    stall_exp_base  = 16'd0;
    stall_exp_delta = 16'd0;
`endif
    rst_n = 1'b0;
    wr_valid0 = 0; wr_data0 = '0; rd_ready0 = 0;
    wr_valid1 = 0; wr_data1 = '0; rd_ready1 = 0;
    repeat (3) tick();

    // reset state
    chk("rst_wr_ready0", wr_ready0, 1);
    chk("rst_rd_valid0", rd_valid0, 0);
    chk("rst_empty0", empty0, 1);
    chk("rst_full0", full0, 0);
    chk("rst_count0", count0, 0);
    chk("rst_wren0", bram_wren0, 0);
    chk("rst_rden0", bram_rden0, 0);
    chk("rst_stall0", stall0, 0);
    chk("rst_wr_ready1", wr_ready1, 1);
    chk("rst_rd_valid1", rd_valid1, 0);
    chk("regce0", bram_regce0, 0);
    chk("regce1", bram_regce1, 1);
    rst_n = 1'b1;
    tick();

    // single word latency from empty, RD_READY low
    push_word0(32'hA5, acc);
    chk("a5_accept", acc, 1);
    chk("a5_rv_c1", rd_valid0, 0);
    chk("a5_count_c1", count0, 1);
    tick();
    chk("a5_rv_c2", rd_valid0, 0);
    tick();
    chk("a5_rv_c3", rd_valid0, 1);
    chk("a5_data", rd_data0, 32'hA5);
    chk("a5_count_c3", count0, 1);
    chk("a5_empty", empty0, 0);
    drain0(10);

    // simultaneous write and pop with one word held
    push_word0(32'h11, acc);
    wait_rv0(10);
    chk("sim_count_pre", count0, 1);
    for (int i = 0; i < 3; i++) begin
      wr_valid0 = 1'b1;
      wr_data0  = 32'h21 + i;
      rd_ready0 = 1'b1;
      if (wr_ready0) exp_q0.push_back(32'h21 + i);
      tick();
      wr_valid0 = 1'b0;
      rd_ready0 = 1'b0;
      chk("sim_count_post", count0, 1);
      wait_rv0(10);
      chk("sim_count_settled", count0, 1);
    end
    drain0(10);

    // fill: 20 attempts, 16 in memory plus 2 in the output buffer
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      push_word0(32'h100 + i, acc);
      acc_n += int'(acc);
    end
    chk("fill_accepted", acc_n, 18);
    chk("fill_full", full0, 1);
    chk("fill_wr_ready", wr_ready0, 0);
    chk("fill_count", count0, 18);
    chk("stall_after_fill", stall0, stall_exp_base);
    stall_before = stall0;
    wr_valid0 = 1'b1;
    wr_data0  = 32'hDEAD;
    repeat (5) tick();
    wr_valid0 = 1'b0;
    chk("stall_delta", stall0 - stall_before, stall_exp_delta);
    chk("stall_count_held", count0, 18);
    drain0(100);

    // reset mid-stream with 7 words held
    for (int i = 0; i < 7; i++) push_word0(32'h200 + i, acc);
    repeat (3) tick();
    chk("mid_count7", count0, 7);
    rst_n = 1'b0;
    exp_q0.delete();
    #1;
    chk("mrst_count", count0, 0);
    chk("mrst_rd_valid", rd_valid0, 0);
    chk("mrst_wr_ready", wr_ready0, 1);
    tick();
    chk("mrst_count_c1", count0, 0);
    chk("mrst_rd_valid_c1", rd_valid0, 0);
    rst_n = 1'b1;
    tick();
    push_word0(32'h3C, acc);
    wait_rv0(10);
    chk("post_rst_first", rd_data0, 32'h3C);
    drain0(10);

    // DO_REG=1 streaming, 100 words with RD_READY held high
    rd_ready1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_valid1 = 1'b1;
      wr_data1  = 32'hC0DE_0000 + i;
      chk("stream_wr_ready1", wr_ready1, 1);
      if (wr_ready1) begin
        exp_q1.push_back(32'hC0DE_0000 + i);
        if (i == 0) first_wr1 = cyc;
      end
      tick();
    end
    wr_valid1 = 1'b0;
    k = 0;
    while (n_pop1 < 100 && k < 200) begin
      tick();
      k++;
    end
    chk("stream_pops", n_pop1, 100);
    chk("stream_fill_latency", first_pop1 - first_wr1, 4);
    chk("stream_throughput", last_pop1 - first_pop1, 99);
    chk("stream_left", exp_q1.size(), 0);
    chk("stream_empty1", empty1, 1);
    chk("stream_count1", count1, 0);
    rd_ready1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
